// File: rtl/rename_pkg.sv
// Shared rename-stage types: architectural/physical register counts
// and the physical register index type used across rename.
package rename_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PS_WIDTH      = $clog2(NUM_PHYS_REGS);

  typedef logic [PS_WIDTH-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Free physical register FIFO feeding the alias table at rename.
// Ports: alloc_req/alloc_pd/alloc_valid pop the head; free_we/free_pd
// push a stale pd from commit; jump_commit restores the list to full;
// free_count is the registered occupancy.
// Optional FREE_LIST_BYPASS_EN: empty list forwards free_pd to alloc.
module free_list #(
  parameter int NUM_REGS  = rename_pkg::NUM_PHYS_REGS,
  parameter int PS_WIDTH  = $clog2(NUM_REGS),
  parameter int DEPTH     = NUM_REGS - rename_pkg::NUM_ARCH_REGS,
  parameter int PTR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  output logic [PS_WIDTH-1:0]  alloc_pd,
  output logic                 alloc_valid,
  input  logic                 free_we,
  input  logic [PS_WIDTH-1:0]  free_pd,
  input  logic                 jump_commit,
  output logic [PTR_WIDTH-1:0] free_count
);

  import rename_pkg::*;

  localparam int IW = PTR_WIDTH - 1;

  logic [PS_WIDTH-1:0]  fl_q [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] cnt_q, cnt_d;

  logic empty, full, byp, push, pop;

  assign empty = rd_ptr_q == wr_ptr_q;
  assign full  = (rd_ptr_q[IW-1:0] == wr_ptr_q[IW-1:0])
              && (rd_ptr_q[IW] != wr_ptr_q[IW]);

`ifdef FREE_LIST_BYPASS_EN
  // Pushed pd handed straight to rename; never enters storage.
  assign byp = empty & free_we & alloc_req & ~jump_commit;
`else
  assign byp = 1'b0;
`endif

  assign push = free_we & ~full & ~byp;
  assign pop  = alloc_req & ~empty & ~jump_commit;

  assign alloc_valid = ~empty | byp;
  assign alloc_pd    = byp ? free_pd : fl_q[rd_ptr_q[IW-1:0]];
  assign free_count  = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop);
    cnt_d    = cnt_q + PTR_WIDTH'(push) - PTR_WIDTH'(pop);
    if (jump_commit) begin
      // Speculatively popped pds are still in storage behind wr_ptr,
      // so making the list full again re-frees exactly those.
      rd_ptr_d = {~wr_ptr_d[IW], wr_ptr_d[IW-1:0]};
      cnt_d    = PTR_WIDTH'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= PTR_WIDTH'(DEPTH);
      cnt_q    <= PTR_WIDTH'(DEPTH);
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        fl_q[i] <= PS_WIDTH'(NUM_ARCH_REGS + i);
    end else if (push) begin
      fl_q[wr_ptr_q[IW-1:0]] <= free_pd;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: expected pops are queued by the
// stimulus and checked by a monitor on every accepted allocation.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req;
  logic [5:0] alloc_pd;
  logic       alloc_valid;
  logic       free_we;
  logic [5:0] free_pd;
  logic       jump_commit;
  logic [5:0] free_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  free_list dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_pd    (alloc_pd),
    .alloc_valid (alloc_valid),
    .free_we     (free_we),
    .free_pd     (free_pd),
    .jump_commit (jump_commit),
    .free_count  (free_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    alloc_req   = 1'b0;
    free_we     = 1'b0;
    free_pd     = '0;
    jump_commit = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pop(int pd);
    exp_q.push_back(pd);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic push(int pd);
    free_we = 1'b1;
    free_pd = 6'(pd);
    tick();
    free_we = 1'b0;
  endtask

  // Monitor: every accepted allocation must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && alloc_req && alloc_valid && !jump_commit) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got %0d expected none", alloc_pd);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(alloc_pd) != e) begin
          n_err++;
          $display("FAIL pop_pd: got %0d expected %0d", alloc_pd, e);
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b1;
    tick();
    do_reset();
    check("rst_count", free_count, 32);
    check("rst_valid", alloc_valid, 1);
    check("rst_pd", alloc_pd, 32);

    // Drain the whole list: 32..63 in order.
    for (int i = 0; i < 32; i++) pop(32 + i);
    check("drain_valid", alloc_valid, 0);
    check("drain_count", free_count, 0);

    // Push into an empty list, then allocate it next cycle.
    push(5);
    check("p5_count", free_count, 1);
    check("p5_pd", alloc_pd, 5);
    pop(5);
    check("p5_empty", free_count, 0);

    // Same-cycle push and allocate on an empty list.
    free_we   = 1'b1;
    free_pd   = 6'd9;
    alloc_req = 1'b1;
`ifdef FREE_LIST_BYPASS_EN
    exp_q.push_back(9);
    check("byp_valid", alloc_valid, 1);
    tick();
    idle();
    check("byp_count", free_count, 0);
`else
    check("nobyp_valid", alloc_valid, 0);
    tick();
    idle();
    check("nobyp_count", free_count, 1);
    pop(9);
`endif

    // Steady state at 10 entries with simultaneous push/pop.
    for (int i = 0; i < 10; i++) push(10 + i);
    check("ss_fill", free_count, 10);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(10 + i);
      alloc_req = 1'b1;
      free_we   = 1'b1;
      free_pd   = 6'(20 + i);
      tick();
      check("ss_count", free_count, 10);
    end
    idle();
    for (int i = 0; i < 10; i++) pop(30 + i);
    check("ss_drain", free_count, 0);

    // Pop 12, commit 3 stale pds, then jump: 32..34 now live in
    // the retirement file, so the free set is 35..63, 2, 6, 9.
    do_reset();
    for (int i = 0; i < 12; i++) pop(32 + i);
    push(2);
    push(6);
    push(9);
    check("j1_pre", free_count, 23);
    jump_commit = 1'b1;
    tick();
    idle();
    check("j1_count", free_count, 32);
    check("j1_head", alloc_pd, 35);
    for (int i = 35; i < 64; i++) pop(i);
    pop(2);
    pop(6);
    pop(9);
    check("j1_drain", free_count, 0);
    check("j1_valid", alloc_valid, 0);

    // Jump with same-cycle push 17 and allocate request.
    do_reset();
    pop(32);
    jump_commit = 1'b1;
    free_we     = 1'b1;
    free_pd     = 6'd17;
    alloc_req   = 1'b1;
    tick();
    idle();
    check("j2_count", free_count, 32);
    check("j2_head", alloc_pd, 33);
    for (int i = 33; i < 64; i++) pop(i);
    pop(17);
    check("j2_drain", free_count, 0);

    // Reset in the middle of a pop/push burst.
    do_reset();
    for (int i = 0; i < 4; i++) pop(32 + i);
    push(7);
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    free_we   = 1'b1;
    free_pd   = 6'd11;
    tick();
    idle();
    rst_n = 1'b1;
    check("mr_count", free_count, 32);
    check("mr_pd", alloc_pd, 32);

    // Push while full is dropped.
    push(3);
    check("full_count", free_count, 32);
    check("full_head", alloc_pd, 32);
    for (int i = 0; i < 32; i++) pop(32 + i);
    check("full_drain", free_count, 0);

    tick();
    check("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
